// File: rtl/vram_arbiter.sv
// ----------------------------------------------------------------------------
// vram_arbiter
//
// Shares the single-port 4K x 16 synchronous text-mode VRAM between the CRTC
// character fetch and the v65C02 CPU bus. A CRTC character strobe (with the
// display active) always wins the RAM port for that cycle. CPU accesses run
// through a small IDLE/ISSUE/DATA/ACK FSM and take the port in any cycle the
// video side leaves free.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   col_stb_i            CRTC character strobe (never in back-to-back cycles)
//   col_i, line_i        CRTC column 0..79 and scan line 0..479
//   video_on_i           CRTC active-display flag; gates the fetch
//   cpu_req_i/we_i       CPU request (held until ack), write select
//   cpu_addr_i/dat_i     CPU word address and write data
//   cpu_dat_o/ack_o      CPU read data and single-cycle completion pulse
//   vid_dat_o/stb_o      fetched character/attribute word and its strobe
//   ram_addr_o/we_o/dat_o registered VRAM address, write enable, write data
//   ram_dat_i            VRAM read data, one cycle after address capture
//
// Pipeline, for an access decided in cycle N:
//   N+1  ram_addr_o/ram_we_o driven     (vld_pipe[1])
//   N+2  ram_dat_i valid                (vld_pipe[2])
//   N+3  vid_stb_o or cpu_ack_o / cpu_dat_o
// ----------------------------------------------------------------------------
module vram_arbiter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        col_stb_i,
   input  logic [6:0]  col_i,
   input  logic [8:0]  line_i,
   input  logic        video_on_i,
   input  logic        cpu_req_i,
   input  logic        cpu_we_i,
   input  logic [11:0] cpu_addr_i,
   input  logic [15:0] cpu_dat_i,
   output logic [15:0] cpu_dat_o,
   output logic        cpu_ack_o,
   output logic [15:0] vid_dat_o,
   output logic        vid_stb_o,
   output logic [11:0] ram_addr_o,
   output logic        ram_we_o,
   output logic [15:0] ram_dat_o,
   input  logic [15:0] ram_dat_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DATA  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   state_t state_q, state_d;

   // ------------------------------------------------------------------------
   // Character-cell address: row*80 + col, with row*80 built as
   // row*64 + row*16 so no multiplier is needed. Max 2399, fits 12 bits.
   // ------------------------------------------------------------------------
   logic [4:0]  row;
   logic [11:0] vid_addr;

   assign row      = line_i[8:4];
   assign vid_addr = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col_i};

   // ------------------------------------------------------------------------
   // Arbitration for this cycle. Video has absolute priority; the CPU only
   // launches from IDLE, so a deferred request simply stays pending in IDLE
   // and goes out the next cycle (strobe spacing guarantees that slot).
   // ------------------------------------------------------------------------
   logic vid_go;
   logic cpu_go;
   logic rd_issue;

   assign vid_go   = col_stb_i & video_on_i;
   assign cpu_go   = ~vid_go & (state_q == S_IDLE) & cpu_req_i;
   assign rd_issue = vid_go | (cpu_go & ~cpu_we_i);

   // ------------------------------------------------------------------------
   // CPU FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (cpu_go) state_d = S_ISSUE;
         S_ISSUE: state_d = S_DATA;
         S_DATA:  state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The ack pulse is exactly the ACK state, so it is a register output and
   // vanishes with the FSM on reset.
   assign cpu_ack_o = (state_q == S_ACK);

   // ------------------------------------------------------------------------
   // Read-return pipeline. vld_pipe marks an outstanding read, tag_pipe
   // says who owns it (1 = video, 0 = CPU). Writes never enter the
   // pipeline: they have no data to return, and the CPU write ack comes
   // from the FSM alone.
   // ------------------------------------------------------------------------
   logic [2:1] vld_pipe;
   logic [2:1] tag_pipe;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[1], rd_issue};
         tag_pipe <= {tag_pipe[1], vid_go};
      end
   end

   // ------------------------------------------------------------------------
   // RAM port registers. Address only moves when an access is launched;
   // write enable is a one-cycle pulse aligned with the ISSUE state.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ram_addr_o <= '0;
         ram_we_o   <= 1'b0;
         ram_dat_o  <= '0;
      end else begin
         ram_we_o <= cpu_go & cpu_we_i;
         if (vid_go)      ram_addr_o <= vid_addr;
         else if (cpu_go) ram_addr_o <= cpu_addr_i;
         if (cpu_go & cpu_we_i) ram_dat_o <= cpu_dat_i;
      end
   end

   // ------------------------------------------------------------------------
   // Return-data routing. cpu_dat_o only loads on CPU reads, so a write ack
   // leaves the last read value in place.
   // ------------------------------------------------------------------------
   logic vid_ret;
   logic cpu_ret;

   assign vid_ret = vld_pipe[2] &  tag_pipe[2];
   assign cpu_ret = vld_pipe[2] & ~tag_pipe[2];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vid_stb_o <= 1'b0;
         vid_dat_o <= '0;
         cpu_dat_o <= '0;
      end else begin
         vid_stb_o <= vid_ret;
         if (vid_ret) vid_dat_o <= ram_dat_i;
         if (cpu_ret) cpu_dat_o <= ram_dat_i;
      end
   end

endmodule
